pwm_fade_ctrl: RTL
==================

# pwm_fade_ctrl

Brightness sequencer for the board's 8-bit LED PWM datapath. Accepts brightness commands over a valid/ready handshake and drives the PWM duty threshold. In ramp mode it slews the duty toward the commanded target at a fixed rate. In breathe mode it cycles the duty continuously between 0 and 255. It sits between the switch/key decode logic and the PWM comparator on the 50 MHz domain, replacing the static switch-to-threshold mapping.

## Interface

Parameters:
- TICK_DIV, default 50000: clock cycles per ramp tick (1 ms at 50 MHz); must be ≥ 2.
- STEP, default 1: duty change per tick, range 1..255.
- HOLD_TICKS, default 250: number of ticks the duty dwells at each breathe extreme; must be ≥ 1.

Ports:
- clk  in  1  50 MHz system clock. All logic is on the rising edge.
- reset_n  in  1  Synchronous, active-low reset.
- cmd_valid  in  1  Command present.
- cmd_ready  out  1  Controller can accept a command.
- cmd_target  in  8  Target duty for a ramp command.
- cmd_breathe  in  1  1 = breathe command (cmd_target ignored); 0 = ramp command.
- duty  out  8  Registered threshold fed to the PWM comparator.
- busy  out  1  High in every state except IDLE.
- at_target  out  1  High exactly when the state is IDLE.

## Operation

- States: IDLE, RAMP, BR_UP, BR_DN, BR_HOLD. A 1-bit direction flag (dir) selects the exit from BR_HOLD.
- Accept: a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
- cmd_ready:
  - 1 in IDLE, BR_UP, BR_DN and BR_HOLD.
  - 0 in RAMP. cmd_valid during RAMP is ignored, with no queuing.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - Cleared to 0 on reset and on every accept.
  - A tick occurs on an edge where the count equals TICK_DIV-1.
  - Ticks have no effect in IDLE.
- Ramp command accepted (any state that accepts):
  - target ← cmd_target.
  - If cmd_target == duty, go to IDLE (or stay there).
  - Otherwise go to RAMP.
- RAMP, on each tick:
  - duty moves toward target by min(STEP, |target−duty|), so it never overshoots.
  - If the new duty equals target, the state becomes IDLE on the same edge.
- Breathe command accepted:
  - From IDLE or BR_HOLD: go to BR_UP with no duty change.
  - From BR_UP or BR_DN: no state change; only the tick counter is cleared.
- BR_UP, on each tick:
  - duty ← min(duty+STEP, 255).
  - On reaching 255: dir ← 0 (next direction down), and go to BR_HOLD.
- BR_DN, on each tick:
  - duty ← max(duty−STEP, 0).
  - On reaching 0: dir ← 1 (next direction up), and go to BR_HOLD.
- BR_HOLD:
  - Counts HOLD_TICKS ticks with duty frozen.
  - On the HOLD_TICKS-th tick, go to BR_UP if dir=1, else BR_DN.
  - The hold counter is cleared on entry.
- Exiting breathe: a ramp command accepted in any breathe state goes to RAMP (or IDLE if equal) from the current duty.
- Arithmetic: duty ± STEP is computed in 9 bits, then clamped to 0..255. The 8-bit value must never wrap.
- Reset while reset_n=0 (applies in any state, including mid-ramp or mid-breathe, and overrides a simultaneous accept):
  - duty=0, target=0, state=IDLE, dir=1.
  - Tick and hold counters = 0.
  - Resulting outputs: cmd_ready=1, busy=0, at_target=1.

## Timing

- duty, state and the counters are registers. cmd_ready, busy and at_target decode combinationally from the state register.
- After an accept at edge E0, the first duty update occurs at edge E0+TICK_DIV. Subsequent updates follow every TICK_DIV cycles.
- Ramp completion:
  - Ticks required = ceil(|target−duty0| / STEP).
  - busy falls on the edge of the final duty update, in the same cycle duty reaches target.
- A command accepted in IDLE with a non-equal target raises busy on the cycle after the accept edge.
- Breathe dwell at each extreme is HOLD_TICKS·TICK_DIV cycles, measured from the edge where duty reaches the extreme.

## Test plan

Parameters for all scenarios: TICK_DIV=4, STEP=16, HOLD_TICKS=2.

- Reset: hold reset_n=0 for 3 cycles, then release. Required: duty=0, cmd_ready=1, busy=0, at_target=1.
- Basic ramp: from duty 0, ramp to 64. Required:
  - duty goes 16, 32, 48, 64 at accept+4, +8, +12, +16 cycles.
  - cmd_ready=0 throughout; at_target=1 from accept+16.
- No overshoot and ignored command: from 64, ramp to 70. Required: a single step to 70 at accept+4. Then ramp to 0. Required:
  - duty goes 54, 38, 22, 6, 0.
  - A cmd_valid with target 200 issued mid-ramp is ignored; the final duty is 0.
- Breathe: from duty 0, issue a breathe command. Required:
  - duty goes 16 … 240, then saturates to 255 (16th tick).
  - Holds 8 cycles, then goes 239 … 15, 0.
  - Holds 8 cycles, then rises again.
  - A ramp command to 128 issued during BR_DN at duty 95 steps 111, 127, 128, then reaches IDLE.
- Equal target: issue target == current duty (e.g. 128). Required: busy stays 0 and duty is unchanged.
- Reset mid-operation: assert reset_n=0 mid-ramp at duty 48, together with a simultaneous cmd_valid. Required: the next edge gives duty=0 in IDLE and the command is not accepted.

Source files
------------

// File: rtl/pwm_fade_ctrl_if.sv
// rtl/pwm_fade_ctrl_if.sv - brightness command handshake between key decode and the fade sequencer
interface pwm_fade_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_target;
  logic       cmd_breathe;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_breathe,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_breathe,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - LED duty sequencer: slews toward a commanded target or breathes 0..255
module pwm_fade_ctrl #(
  parameter int TICK_DIV   = 50000,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 250
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pwm_fade_ctrl_if.slave        cmd,
  output logic [7:0]            duty,
  output logic                  busy,
  output logic                  at_target
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [8:0]    STEP9     = 9'(STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_BR_UP,
    S_BR_DN,
    S_BR_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      duty_q, duty_d;
  logic [7:0]      target_q, target_d;
  logic            dir_q, dir_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

  logic            accept;
  logic            tick;
  logic [8:0]      up9;
  logic [8:0]      dn9;
  logic [8:0]      gap9;
  logic [7:0]      sat_up;
  logic [7:0]      sat_dn;

  assign accept = cmd.cmd_valid & cmd.cmd_ready;
  assign tick   = (tick_cnt_q == TICK_LAST);

  // 9-bit sums so the duty saturates instead of wrapping; bit 8 of dn9 flags a borrow.
  assign up9    = {1'b0, duty_q} + STEP9;
  assign dn9    = {1'b0, duty_q} - STEP9;
  assign sat_up = up9[8] ? 8'hFF : up9[7:0];
  assign sat_dn = dn9[8] ? 8'h00 : dn9[7:0];
  assign gap9   = (target_q > duty_q) ? ({1'b0, target_q} - {1'b0, duty_q})
                                      : ({1'b0, duty_q} - {1'b0, target_q});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      duty_q     <= 8'd0;
      target_q   <= 8'd0;
      dir_q      <= 1'b1;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      dir_q      <= dir_d;
      tick_cnt_q <= tick_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    dir_d      = dir_q;
    hold_cnt_d = hold_cnt_q;

    if (accept || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    if (accept) begin
      if (cmd.cmd_breathe) begin
        // Re-issuing breathe while already sweeping only restarts the tick phase.
        if (state_q == S_IDLE || state_q == S_BR_HOLD) begin
          state_d = S_BR_UP;
        end
      end else begin
        target_d = cmd.cmd_target;
        state_d  = (cmd.cmd_target == duty_q) ? S_IDLE : S_RAMP;
      end
    end else if (tick) begin
      case (state_q)
        S_RAMP: begin
          if (gap9 <= STEP9) begin
            duty_d  = target_q;
            state_d = S_IDLE;
          end else if (target_q > duty_q) begin
            duty_d = up9[7:0];
          end else begin
            duty_d = dn9[7:0];
          end
        end
        S_BR_UP: begin
          duty_d = sat_up;
          if (sat_up == 8'hFF) begin
            dir_d      = 1'b0;
            hold_cnt_d = '0;
            state_d    = S_BR_HOLD;
          end
        end
        S_BR_DN: begin
          duty_d = sat_dn;
          if (sat_dn == 8'h00) begin
            dir_d      = 1'b1;
            hold_cnt_d = '0;
            state_d    = S_BR_HOLD;
          end
        end
        S_BR_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            state_d    = dir_q ? S_BR_UP : S_BR_DN;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    cmd.cmd_ready = (state_q != S_RAMP);
    busy          = (state_q != S_IDLE);
    at_target     = (state_q == S_IDLE);
  end

  assign duty = duty_q;

endmodule
